mem_io_bridge: RTL and testbench
================================

Name: mem_io_bridge

Overview:
- Sits directly downstream of the multicycle cpu's memory port (address, write data, write enable) and upstream of Memoria.
- Decodes each access to RAM (Memoria), to a small memory-mapped I/O/timer register file, or to unmapped space, and returns read data with the same one-cycle latency as Memoria.
- Adds a programmable timer with a pending-interrupt flag and a synchronised input port, so programs can do timed I/O without touching the cpu datapath.

Parameters:
- RAM_LIMIT, 32'h0000_0100: first byte address beyond RAM (Memoria is 256 bytes).
- IO_BASE, 32'h0000_FF00: base address of the I/O register window (6 word registers, offsets 0x00–0x14).
- SYNC_STAGES, 2: flip-flop stages on io_in.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  32  byte address from cpu.
- cpu_wdata  in  32  store data from cpu.
- cpu_we  in  1  write strobe from cpu.
- cpu_rdata  out  32  read data to cpu; valid one cycle after address.
- mem_addr  out  32  address to Memoria.
- mem_wdata  out  32  write data to Memoria.
- mem_we  out  1  Memoria write enable.
- mem_rdata  in  32  Memoria read data (1-cycle latency).
- io_in  in  32  asynchronous external input port.
- io_out  out  32  output port register.
- timer_irq  out  1  level interrupt: pending AND irq_en.
- err_unmapped  out  1  one-cycle pulse on an unmapped access.

Behaviour:
- Clocking and reset:
  - One clock, clk. reset is synchronous, active-high.
  - On reset: io_out=0, COUNT=0, CMP=32'hFFFF_FFFF, CTRL=0, pending=0, sync chain=0, sel_q=RAM, cpu_rdata source=0, err_unmapped=0, timer_irq=0.
- Address decode (combinational on cpu_addr):
  - RAM: cpu_addr < RAM_LIMIT.
  - IO: IO_BASE <= cpu_addr < IO_BASE+0x18, word-aligned.
  - UNMAPPED: anything else, including a misaligned IO address.
- RAM path:
  - mem_addr=cpu_addr and mem_wdata=cpu_wdata, always (pass-through).
  - mem_we=cpu_we only when decode is RAM; otherwise 0.
- Read latency:
  - Decode select and IO read value are registered at the clk edge (sel_q, io_rdata_q).
  - cpu_rdata = mem_rdata if sel_q==RAM, io_rdata_q if IO, 0 if UNMAPPED.
  - All three regions therefore have exactly one cycle of latency.
- IO register map (offset: name):
  - 0x00 IO_OUT: RW.
  - 0x04 IO_IN: RO, last sync stage; writes ignored.
  - 0x08 COUNT: RW.
  - 0x0C CMP: RW.
  - 0x10 CTRL: RW; bit0 en, bit1 irq_en, bit2 autoreload; other bits read 0.
  - 0x14 STATUS: bit0 pending; write 1 to bit0 clears it; other bits read 0.
- Timer, each cycle when en=1:
  - If COUNT==CMP: pending is set; COUNT becomes 0 if autoreload=1, else COUNT+1.
  - Otherwise COUNT increments.
  - COUNT wraps 32'hFFFF_FFFF -> 0 silently.
  - When en=0, COUNT holds and no match is evaluated.
- Simultaneous events:
  - A cpu write to COUNT in the same cycle as a match: the written value wins and pending is NOT set that cycle.
  - A write to CMP in the same cycle as a match: the match uses the old CMP.
  - A STATUS W1C in the same cycle as a new match: set wins, pending stays 1.
  - A CTRL write takes effect from the next cycle.
- Unmapped access:
  - Writes are dropped; mem_we stays 0.
  - The read returns 0 next cycle.
  - err_unmapped pulses for 1 cycle, registered, aligned with the returned data.
- timer_irq = pending & irq_en, combinational from registers.
- Reset asserted mid-timer-count or mid-read overrides everything on that edge.

Decomposition:
- Package mem_io_pkg holds:
  - the region enum (RAM, IO, UNMAPPED);
  - register offset localparams (OFF_IO_OUT..OFF_STATUS);
  - CTRL bit indices;
  - the CMP reset value.
- Sub-module io_timer holds COUNT, CMP, CTRL, pending and the match logic. Its interface is write strobe, offset, wdata, read data and irq.
- The bridge keeps the decode, the io_in sync chain, IO_OUT and the read mux.

Test Plan:
- RAM write then read: write 0xDEADBEEF at 0x40, then read 0x40. Expect mem_we=1 only in the write cycle, and cpu_rdata=0xDEADBEEF one cycle after the read address.
- IO_OUT and unmapped: write 0x000000A5 to IO_BASE+0x00. Expect io_out=0xA5 the next cycle and mem_we=0. Then read 0x00001000: expect cpu_rdata=0 and an err_unmapped pulse of exactly 1 cycle.
- Timer autoreload: CMP=3, CTRL=0b111. Expect COUNT sequence 0,1,2,3,0,1…; pending=1 and timer_irq=1 from the cycle after the first match. Write 1 to STATUS: pending=0 unless a match occurs that cycle.
- Write priority at match: CMP=5, en=1, and write COUNT=100 in the same cycle COUNT==5. Expect COUNT=100 and pending=0.
- Input sync: toggle io_in to 0x12345678. A read of IO_IN returns it no earlier than SYNC_STAGES+1 cycles after the change.
- Reset mid-run: assert reset for 1 cycle while COUNT=7 and pending=1. Expect COUNT=0, pending=0, timer_irq=0, io_out=0, and CMP=0xFFFFFFFF after the edge.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared types and constants for the cpu memory/IO bridge: region codes,
// IO register offsets, CTRL bit positions and timer reset values.
package mem_io_pkg;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_UNMAPPED
  } region_e;

  localparam int unsigned OFF_W = 5;

  localparam logic [OFF_W-1:0] OFF_IO_OUT = 5'h00;
  localparam logic [OFF_W-1:0] OFF_IO_IN  = 5'h04;
  localparam logic [OFF_W-1:0] OFF_COUNT  = 5'h08;
  localparam logic [OFF_W-1:0] OFF_CMP    = 5'h0C;
  localparam logic [OFF_W-1:0] OFF_CTRL   = 5'h10;
  localparam logic [OFF_W-1:0] OFF_STATUS = 5'h14;

  localparam logic [31:0] IO_WINDOW_BYTES = 32'h0000_0018;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_AUTORELOAD = 2;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_io_bridge_io_timer.sv
// Programmable compare timer: COUNT, CMP, CTRL and the pending flag, with
// cpu register access through a write strobe, word offset and read mux.
module io_timer
  import mem_io_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             irq_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;
  logic        match;
  logic        wr_count;

  always_comb begin
    wr_count  = we_i && (off_i == OFF_COUNT);
    match     = ctrl_q[CTRL_EN] && (count_q == cmp_q);
    count_d   = count_q;
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;

    if (ctrl_q[CTRL_EN]) begin
      count_d = (match && ctrl_q[CTRL_AUTORELOAD]) ? 32'd0 : count_q + 32'd1;
    end
    if (we_i && (off_i == OFF_STATUS) && wdata_i[0]) begin
      pending_d = 1'b0;
    end
    // A new match beats a same-cycle clear, but a cpu COUNT write suppresses it.
    if (match && !wr_count) begin
      pending_d = 1'b1;
    end
    if (wr_count) begin
      count_d = wdata_i;
    end
    if (we_i && (off_i == OFF_CMP)) begin
      cmp_d = wdata_i;
    end
    if (we_i && (off_i == OFF_CTRL)) begin
      ctrl_d = wdata_i[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      cmp_q     <= CMP_RESET;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      OFF_COUNT:  rdata_o = count_q;
      OFF_CMP:    rdata_o = cmp_q;
      OFF_CTRL:   rdata_o = {29'd0, ctrl_q};
      OFF_STATUS: rdata_o = {31'd0, pending_q};
      default:    rdata_o = '0;
    endcase
  end

  assign irq_o = pending_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/mem_io_bridge.sv
// Address decoder between the cpu memory port and Memoria: routes accesses to
// RAM, the IO/timer register window or unmapped space with one-cycle reads.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter logic [31:0] RAM_LIMIT   = 32'h0000_0100,
  parameter logic [31:0] IO_BASE     = 32'h0000_FF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] io_in,
  output logic [31:0] io_out,
  output logic        timer_irq,
  output logic        err_unmapped
);

  region_e          region;
  region_e          sel_q;
  logic [31:0]      io_off_full;
  logic [OFF_W-1:0] io_off;
  logic             io_we;
  logic [31:0]      io_out_q;
  logic [31:0]      io_rdata_d, io_rdata_q;
  logic [31:0]      timer_rdata;
  logic             err_q;
  logic [31:0]      sync_q [SYNC_STAGES];

  assign io_off_full = cpu_addr - IO_BASE;
  assign io_off      = io_off_full[OFF_W-1:0];

  // Misaligned addresses inside the IO window fall through to unmapped.
  always_comb begin
    region = REGION_UNMAPPED;
    if (cpu_addr < RAM_LIMIT) begin
      region = REGION_RAM;
    end else if ((cpu_addr >= IO_BASE) && (io_off_full < IO_WINDOW_BYTES) &&
                 (cpu_addr[1:0] == 2'b00)) begin
      region = REGION_IO;
    end
  end

  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_we    = cpu_we && (region == REGION_RAM);
  assign io_we     = cpu_we && (region == REGION_IO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  io_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .we_i    (io_we),
    .off_i   (io_off),
    .wdata_i (cpu_wdata),
    .rdata_o (timer_rdata),
    .irq_o   (timer_irq)
  );

  always_comb begin
    io_rdata_d = timer_rdata;
    case (io_off)
      OFF_IO_OUT: io_rdata_d = io_out_q;
      OFF_IO_IN:  io_rdata_d = sync_q[SYNC_STAGES-1];
      default:    io_rdata_d = timer_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_out_q   <= '0;
      sel_q      <= REGION_RAM;
      io_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (io_we && (io_off == OFF_IO_OUT)) begin
        io_out_q <= cpu_wdata;
      end
      sel_q      <= region;
      io_rdata_q <= io_rdata_d;
      err_q      <= (region == REGION_UNMAPPED);
    end
  end

  always_comb begin
    cpu_rdata = '0;
    case (sel_q)
      REGION_RAM: cpu_rdata = mem_rdata;
      REGION_IO:  cpu_rdata = io_rdata_q;
      default:    cpu_rdata = '0;
    endcase
  end

  assign io_out       = io_out_q;
  assign err_unmapped = err_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: reads queue their expected data/error,
// a negedge monitor pops and compares one cycle after each read address.
module tb_mem_io_bridge;

  localparam logic [31:0] IOB     = 32'h0000_FF00;
  localparam logic [31:0] A_OUT   = IOB + 32'h00;
  localparam logic [31:0] A_IN    = IOB + 32'h04;
  localparam logic [31:0] A_COUNT = IOB + 32'h08;
  localparam logic [31:0] A_CMP   = IOB + 32'h0C;
  localparam logic [31:0] A_CTRL  = IOB + 32'h10;
  localparam logic [31:0] A_STAT  = IOB + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] io_in;
  logic [31:0] io_out;
  logic        timer_irq;
  logic        err_unmapped;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic rd_req;
  logic rd_valid = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] ram [64];

  always #5 clk = ~clk;

  mem_io_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_rdata    (cpu_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .io_in        (io_in),
    .io_out       (io_out),
    .timer_irq    (timer_irq),
    .err_unmapped (err_unmapped)
  );

  // Behavioural Memoria: 64 words, registered read-before-write.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  always @(posedge clk) rd_valid <= rd_req;

  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got read data %h with empty queue, expected an entry", cpu_rdata);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_data"}, cpu_rdata, mon_e.rdata);
        chk({mon_e.name, "_err"}, {31'd0, err_unmapped}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rd);
    @(negedge clk);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = we;
    rd_req    = rd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 1'b1, 1'b0);
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic err, input string name);
    exp_t e;
    e.name  = name;
    e.rdata = exp;
    e.err   = err;
    sb.push_back(e);
    drive(a, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq [6];
    seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; io_in = '0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_io_out", io_out, 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    chk("rst_err", {31'd0, err_unmapped}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    reset = 1'b0;

    // RAM write then read
    wr(32'h40, 32'hDEAD_BEEF);       #1 chk("ram_we_wr", {31'd0, mem_we}, 32'd1);
    rd(32'h40, 32'hDEAD_BEEF, 1'b0, "ram_rd"); #1 chk("ram_we_rd", {31'd0, mem_we}, 32'd0);

    // IO_OUT, unmapped and decode boundaries
    wr(A_OUT, 32'h0000_00A5);        #1 chk("io_we_blocked", {31'd0, mem_we}, 32'd0);
    rd(32'h1000, 32'd0, 1'b1, "unmapped"); #1 chk("io_out_val", io_out, 32'h0000_00A5);
    idle();
    idle();                          #1 chk("err_pulse_end", {31'd0, err_unmapped}, 32'd0);
    rd(A_OUT, 32'h0000_00A5, 1'b0, "io_out_rd");
    wr(32'h100, 32'h1111_1111);      #1 chk("ram_limit_we", {31'd0, mem_we}, 32'd0);
    rd(32'hFC, 32'd0, 1'b0, "ram_top");
    rd(IOB + 32'h2, 32'd0, 1'b1, "misaligned");
    rd(IOB + 32'h18, 32'd0, 1'b1, "past_window");
    wr(A_IN, 32'hFFFF_FFFF);
    rd(A_IN, 32'd0, 1'b0, "io_in_ro");

    // Autoreload timer, pending and W1C collisions
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'd7);
    for (int i = 0; i < 6; i++) begin
      rd(A_COUNT, seq[i], 1'b0, "cnt_ar");
      #1 chk("irq_ar", {31'd0, timer_irq}, (i >= 4) ? 32'd1 : 32'd0);
    end
    rd(A_STAT, 32'd1, 1'b0, "st_pend");
    wr(A_STAT, 32'd1);
    rd(A_STAT, 32'd1, 1'b0, "st_set_wins");
    wr(A_STAT, 32'd1);
    rd(A_STAT, 32'd0, 1'b0, "st_cleared"); #1 chk("irq_cleared", {31'd0, timer_irq}, 32'd0);
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'd1);
    wr(A_COUNT, 32'd0);

    // COUNT write beats a same-cycle match
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'hFFFF_FFF9);
    repeat (4) idle();
    rd(A_COUNT, 32'd4, 1'b0, "cnt_before_hit");
    wr(A_COUNT, 32'd100);
    rd(A_COUNT, 32'd100, 1'b0, "cnt_written");
    rd(A_STAT, 32'd0, 1'b0, "st_no_pend");
    rd(A_CTRL, 32'd1, 1'b0, "ctrl_mask");

    // io_in synchroniser latency
    rd(A_IN, 32'd0, 1'b0, "sync_0");
    io_in = 32'h1234_5678;
    rd(A_IN, 32'd0, 1'b0, "sync_1");
    rd(A_IN, 32'h1234_5678, 1'b0, "sync_2");

    // Reset in the middle of a running count with pending set
    wr(A_CTRL, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'd3);
    repeat (6) idle();
    rd(A_COUNT, 32'd6, 1'b0, "cnt_pre_rst");
    idle();
    reset = 1'b1;                    #1 chk("irq_pre_rst", {31'd0, timer_irq}, 32'd1);
    idle();
    reset = 1'b0;                    #1 chk("irq_post_rst", {31'd0, timer_irq}, 32'd0);
    chk("io_out_post_rst", io_out, 32'd0);
    rd(A_COUNT, 32'd0, 1'b0, "cnt_post_rst");
    rd(A_CMP, 32'hFFFF_FFFF, 1'b0, "cmp_post_rst");
    rd(A_STAT, 32'd0, 1'b0, "st_post_rst");
    rd(A_CTRL, 32'd0, 1'b0, "ctrl_post_rst");
    rd(A_OUT, 32'd0, 1'b0, "io_out_rd_post_rst");
    repeat (3) idle();
    chk("sb_drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
